// File: rtl/spi_slave_rx.sv
// SPI mode-0 receive slave: oversampled pins, word assembly on rx_data/rx_valid,
// and a reply word shifted out on MISO, reloaded at each word boundary.
module spi_slave_rx #(
    parameter int unsigned P_DATA_W      = 8,
    parameter int unsigned P_SYNC_STAGES = 2,
    parameter int unsigned P_MSB_FIRST   = 1
) (
    input  logic                clk,
    input  logic                a_rst,
    input  logic                sclk,
    input  logic                cs_n,
    input  logic                mosi,
    output logic                miso,
    output logic                miso_oe,
    input  logic [P_DATA_W-1:0] tx_data,
    output logic [P_DATA_W-1:0] rx_data,
    output logic                rx_valid,
    output logic                frame_err,
    output logic                busy
);
    localparam int unsigned CNT_W = $clog2(P_DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(P_DATA_W - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [P_SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [P_SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [P_SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                     sclk_last_q, cs_last_q;
    logic                     sclk_s, cs_n_s, mosi_s;
    logic                     sclk_pe, sclk_ne, cs_fe, cs_re;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [P_DATA_W-1:0]   tx_shift_q, tx_shift_d;
    logic [P_DATA_W-1:0]   rx_shift_q, rx_shift_d;
    logic [P_DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  miso_q, miso_d;
    logic                  miso_oe_q, miso_oe_d;
    logic                  busy_q, busy_d;
    logic [P_DATA_W-1:0]   rx_next;
    logic [CNT_W-1:0]      tx_idx;
    logic                  tx_first;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[P_SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[P_SYNC_STAGES-2:0], cs_n};
        mosi_sync_d = {mosi_sync_q[P_SYNC_STAGES-2:0], mosi};
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_last_q <= 1'b0;
            cs_last_q   <= 1'b1;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_last_q <= sclk_s;
            cs_last_q   <= cs_n_s;
        end
    end

    assign sclk_s  = sclk_sync_q[P_SYNC_STAGES-1];
    assign cs_n_s  = cs_sync_q[P_SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_q[P_SYNC_STAGES-1];
    assign sclk_pe = sclk_s & ~sclk_last_q;
    assign sclk_ne = ~sclk_s & sclk_last_q;
    assign cs_fe   = ~cs_n_s & cs_last_q;
    assign cs_re   = cs_n_s & ~cs_last_q;

    // Shift toward the first-bit end so the first received bit lands at MSB or LSB.
    always_comb begin
        if (P_MSB_FIRST != 0) begin
            rx_next  = {rx_shift_q[P_DATA_W-2:0], mosi_s};
            tx_idx   = LAST_BIT - bit_cnt_q;
            tx_first = tx_data[P_DATA_W-1];
        end else begin
            rx_next  = {mosi_s, rx_shift_q[P_DATA_W-1:1]};
            tx_idx   = bit_cnt_q;
            tx_first = tx_data[0];
        end
    end

    // The reply is indexed by bit_cnt, so after a word wraps the next falling edge
    // naturally presents the first bit of the freshly reloaded word.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (cs_fe) begin
                    state_d    = ACTIVE;
                    tx_shift_d = tx_data;
                    rx_shift_d = '0;
                    miso_d     = tx_first;
                    bit_cnt_d  = '0;
                    miso_oe_d  = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_re) begin
                    state_d     = IDLE;
                    frame_err_d = (bit_cnt_q != '0);
                    miso_d      = 1'b0;
                    miso_oe_d   = 1'b0;
                    busy_d      = 1'b0;
                    bit_cnt_d   = '0;
                end else if (sclk_pe) begin
                    rx_shift_d = rx_next;
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d  = rx_next;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        tx_shift_d = tx_data;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_ne) begin
                    miso_d = tx_shift_q[tx_idx];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            busy_q      <= busy_d;
        end
    end

    assign miso      = miso_q;
    assign miso_oe   = miso_oe_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: an MSB-first and an LSB-first instance share
// the SPI pins; a bit-banged master drives words at sclk = clk/16.
`timescale 1ns/1ps
module tb_spi_slave_rx;
    logic       clk = 1'b0;
    logic       a_rst = 1'b1;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic [7:0] tx_data = 8'h00;

    logic       miso0, miso_oe0, rx_valid0, frame_err0, busy0;
    logic [7:0] rx_data0;
    logic       miso1, miso_oe1, rx_valid1, frame_err1, busy1;
    logic [7:0] rx_data1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int vcnt0 = 0, ecnt0 = 0, vcnt1 = 0, viol = 0;
    int rv_cyc = 0, rise_cyc = 0;
    logic [7:0] rx_log[$];
    logic prev_valid = 1'b0;

    spi_slave_rx #(.P_DATA_W(8), .P_SYNC_STAGES(2), .P_MSB_FIRST(1)) dut0 (
        .clk(clk), .a_rst(a_rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso0), .miso_oe(miso_oe0), .tx_data(tx_data), .rx_data(rx_data0),
        .rx_valid(rx_valid0), .frame_err(frame_err0), .busy(busy0));

    spi_slave_rx #(.P_DATA_W(8), .P_SYNC_STAGES(2), .P_MSB_FIRST(0)) dut1 (
        .clk(clk), .a_rst(a_rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso1), .miso_oe(miso_oe1), .tx_data(tx_data), .rx_data(rx_data1),
        .rx_valid(rx_valid1), .frame_err(frame_err1), .busy(busy1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid0) begin
            vcnt0 = vcnt0 + 1;
            rv_cyc = cyc;
            rx_log.push_back(rx_data0);
        end
        if (frame_err0) ecnt0 = ecnt0 + 1;
        if (rx_valid1) vcnt1 = vcnt1 + 1;
        if ((rx_valid0 && frame_err0) || (rx_valid0 && prev_valid)) viol = viol + 1;
        prev_valid = rx_valid0;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame();
        @(negedge clk);
        cs_n = 1'b0;
        wait_clk(8);
    endtask

    task automatic end_frame();
        wait_clk(8);
        cs_n = 1'b1;
        wait_clk(8);
    endtask

    // Master samples MISO just before raising sclk; next_tx is applied after the first rise.
    task automatic send_word(input logic [7:0] w, input logic [7:0] next_tx,
                             input int nbits, input bit lsb, output logic [7:0] got);
        int idx;
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            idx = lsb ? i : 7 - i;
            mosi = w[idx];
            wait_clk(8);
            got[idx] = lsb ? miso1 : miso0;
            sclk = 1'b1;
            rise_cyc = cyc;
            if (i == 0) tx_data = next_tx;
            wait_clk(8);
            sclk = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1;
        total++; if ({miso0, miso_oe0, rx_valid0, frame_err0, busy0} !== 5'b0 || rx_data0 !== 8'h00) begin
            bad++; $display("FAIL reset_outputs: got miso=%b oe=%b v=%b err=%b busy=%b rx=%h, want all 0",
                            miso0, miso_oe0, rx_valid0, frame_err0, busy0, rx_data0);
        end
        wait_clk(3);
        a_rst = 1'b0;
        wait_clk(4);
        total++; if (busy0 !== 1'b0 || miso_oe0 !== 1'b0) begin
            bad++; $display("FAIL reset_idle: busy=%b oe=%b want 0 0", busy0, miso_oe0);
        end
    endtask

    task automatic test_single();
        logic [7:0] got;
        int v0, e0;
        v0 = vcnt0; e0 = ecnt0;
        tx_data = 8'h3C;
        start_frame();
        total++; if (busy0 !== 1'b1 || miso_oe0 !== 1'b1) begin
            bad++; $display("FAIL single_busy: busy=%b oe=%b want 1 1", busy0, miso_oe0);
        end
        send_word(8'hA5, 8'h3C, 8, 1'b0, got);
        end_frame();
        total++; if (vcnt0 - v0 !== 1) begin
            bad++; $display("FAIL single_valid_cnt: got %0d want 1", vcnt0 - v0);
        end
        total++; if (rx_data0 !== 8'hA5) begin
            bad++; $display("FAIL single_rx: got %h want a5", rx_data0);
        end
        total++; if (got !== 8'h3C) begin
            bad++; $display("FAIL single_miso: got %h want 3c", got);
        end
        total++; if (rv_cyc - rise_cyc < 3 || rv_cyc - rise_cyc > 5) begin
            bad++; $display("FAIL single_latency: got %0d want 3..5", rv_cyc - rise_cyc);
        end
        total++; if (busy0 !== 1'b0 || miso_oe0 !== 1'b0 || miso0 !== 1'b0 || ecnt0 !== e0) begin
            bad++; $display("FAIL single_end: busy=%b oe=%b miso=%b errs=%0d want 0 0 0 0",
                            busy0, miso_oe0, miso0, ecnt0 - e0);
        end
    endtask

    task automatic test_abort();
        logic [7:0] got;
        int v0, e0;
        v0 = vcnt0; e0 = ecnt0;
        start_frame();
        send_word(8'hFF, 8'h00, 5, 1'b0, got);
        end_frame();
        total++; if (ecnt0 - e0 !== 1) begin
            bad++; $display("FAIL abort_err: got %0d pulses want 1", ecnt0 - e0);
        end
        total++; if (vcnt0 - v0 !== 0 || rx_data0 !== 8'hA5) begin
            bad++; $display("FAIL abort_hold: valids=%0d rx=%h want 0 a5", vcnt0 - v0, rx_data0);
        end
        start_frame();
        send_word(8'h5A, 8'h00, 8, 1'b0, got);
        end_frame();
        total++; if (rx_data0 !== 8'h5A || vcnt0 - v0 !== 1 || ecnt0 - e0 !== 1) begin
            bad++; $display("FAIL abort_recover: rx=%h valids=%0d errs=%0d want 5a 1 1",
                            rx_data0, vcnt0 - v0, ecnt0 - e0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] g0, g1, g2;
        int v0, base;
        v0 = vcnt0; base = rx_log.size();
        tx_data = 8'h11;
        start_frame();
        send_word(8'h01, 8'h22, 8, 1'b0, g0);
        send_word(8'h80, 8'h33, 8, 1'b0, g1);
        send_word(8'hFF, 8'h33, 8, 1'b0, g2);
        end_frame();
        total++; if (vcnt0 - v0 !== 3) begin
            bad++; $display("FAIL b2b_valid_cnt: got %0d want 3", vcnt0 - v0);
        end else begin
            total++; if (rx_log[base] !== 8'h01 || rx_log[base+1] !== 8'h80 || rx_log[base+2] !== 8'hFF) begin
                bad++; $display("FAIL b2b_rx: got %h %h %h want 01 80 ff",
                                rx_log[base], rx_log[base+1], rx_log[base+2]);
            end
        end
        total++; if (g0 !== 8'h11 || g1 !== 8'h22 || g2 !== 8'h33) begin
            bad++; $display("FAIL b2b_miso: got %h %h %h want 11 22 33", g0, g1, g2);
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] got;
        int v1;
        v1 = vcnt1;
        tx_data = 8'h80;
        start_frame();
        send_word(8'h01, 8'h80, 8, 1'b1, got);
        end_frame();
        total++; if (rx_data1 !== 8'h01 || vcnt1 - v1 !== 1) begin
            bad++; $display("FAIL lsb_rx: rx=%h valids=%0d want 01 1", rx_data1, vcnt1 - v1);
        end
        total++; if (got !== 8'h80) begin
            bad++; $display("FAIL lsb_miso: got %h want 80", got);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        int v0;
        tx_data = 8'hFF;
        start_frame();
        send_word(8'hC3, 8'hFF, 4, 1'b0, got);
        a_rst = 1'b1;
        #1;
        total++; if ({miso0, miso_oe0, rx_valid0, frame_err0, busy0} !== 5'b0 || rx_data0 !== 8'h00) begin
            bad++; $display("FAIL rstmid_outputs: miso=%b oe=%b v=%b err=%b busy=%b rx=%h want all 0",
                            miso0, miso_oe0, rx_valid0, frame_err0, busy0, rx_data0);
        end
        cs_n = 1'b1;
        wait_clk(4);
        a_rst = 1'b0;
        wait_clk(4);
        v0 = vcnt0;
        start_frame();
        send_word(8'hC3, 8'h00, 8, 1'b0, got);
        end_frame();
        total++; if (rx_data0 !== 8'hC3 || vcnt0 - v0 !== 1) begin
            bad++; $display("FAIL rstmid_recover: rx=%h valids=%0d want c3 1", rx_data0, vcnt0 - v0);
        end
    endtask

    task automatic test_idle_noise();
        int v0, e0;
        v0 = vcnt0; e0 = ecnt0;
        cs_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mosi = ~mosi;
            sclk = 1'b1; wait_clk(8);
            sclk = 1'b0; wait_clk(8);
        end
        total++; if (vcnt0 - v0 !== 0 || ecnt0 - e0 !== 0) begin
            bad++; $display("FAIL idle_pulses: valids=%0d errs=%0d want 0 0", vcnt0 - v0, ecnt0 - e0);
        end
        total++; if (busy0 !== 1'b0 || miso_oe0 !== 1'b0 || miso0 !== 1'b0) begin
            bad++; $display("FAIL idle_outputs: busy=%b oe=%b miso=%b want 0 0 0", busy0, miso_oe0, miso0);
        end
    endtask

    task automatic test_invariants();
        total++; if (viol !== 0) begin
            bad++; $display("FAIL pulse_rules: got %0d violations want 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_abort();
        test_back_to_back();
        test_lsb_first();
        test_reset_mid();
        test_idle_noise();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
